// File: rtl/wb_move_seq_if.sv
// Wishbone classic slave bus bundle for the servo move sequencer.
interface wb_move_seq_if;
  logic [31:0] wb_adr_i;
  logic [31:0] wb_dat_i;
  logic [31:0] wb_dat_o;
  logic [3:0]  wb_sel_i;
  logic        wb_stb_i;
  logic        wb_cyc_i;
  logic        wb_we_i;
  logic        wb_ack_o;

  modport slave (
    input  wb_adr_i, wb_dat_i, wb_sel_i, wb_stb_i, wb_cyc_i, wb_we_i,
    output wb_dat_o, wb_ack_o
  );

  modport master (
    output wb_adr_i, wb_dat_i, wb_sel_i, wb_stb_i, wb_cyc_i, wb_we_i,
    input  wb_dat_o, wb_ack_o
  );
endinterface

// File: rtl/wb_move_seq.sv
// Queues servo move commands from the CPU and replays them to the PWM block,
// holding each move for its programmed number of milliseconds.
module wb_move_seq #(
  parameter int clk_freq = 100000000,
  parameter int depth    = 16
) (
  input  logic               clk,
  input  logic               rst,
  wb_move_seq_if.slave       wb,
  output logic               pw_we,
  output logic [2:0]         pw_ch,
  output logic [15:0]        pw_val,
  output logic               busy,
  output logic               intr
);

  localparam int TICKS = clk_freq / 1000;
  localparam int AW    = $clog2(depth);
  localparam int CW    = AW + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, HOLD} state_t;

  state_t          state_q, state_d;
  logic            ack_q;
  logic [31:0]     dat_q;
  logic            run_q, ie_q, ovf_q, drained_q;
  logic [15:0]     done_q;
  logic [2:0]      pwCh_q;
  logic [15:0]     pwVal_q;
  logic [12:0]     holdCnt_q;
  logic [31:0]     presc_q;
  logic [31:0]     mem [depth];
  logic [AW-1:0]   rdPtr_q, wrPtr_q;
  logic [CW-1:0]   count_q;

  logic            access, wrEn, cmdWr, statWr, ctrlWr, doneWr, flush, push;
  logic            full, empty, tick, drainNow;
  logic            popEn, loadEn, complete, holdStart;
  logic [1:0]      regSel;
  logic [AW-1:0]   headIdx;
  logic [31:0]     headWord, readMux;
  logic            unusedBits;

  assign unusedBits = ^{wb.wb_sel_i, wb.wb_adr_i[31:4], wb.wb_adr_i[1:0]};

  assign access = wb.wb_stb_i & wb.wb_cyc_i & ~ack_q;
  assign wrEn   = access & wb.wb_we_i;
  assign regSel = wb.wb_adr_i[3:2];
  assign cmdWr  = wrEn & (regSel == 2'd0);
  assign statWr = wrEn & (regSel == 2'd1);
  assign ctrlWr = wrEn & (regSel == 2'd2);
  assign doneWr = wrEn & (regSel == 2'd3);
  assign flush  = ctrlWr & wb.wb_dat_i[1];
  assign full   = (count_q == CW'(depth));
  assign empty  = (count_q == '0);
  // A flush in the same cycle discards the push outright.
  assign push   = cmdWr & ~full & ~flush;

  // Back-to-back zero-hold moves load the entry behind the one being popped.
  assign headIdx  = (state_q == ISSUE) ? rdPtr_q + AW'(1) : rdPtr_q;
  assign headWord = mem[headIdx];
  assign tick     = (state_q == HOLD) && (presc_q == 32'(TICKS - 1));
  assign drainNow = (state_q == ISSUE) ? ((count_q == CW'(1)) && !push)
                                       : (empty && !push);

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    popEn     = 1'b0;
    loadEn    = 1'b0;
    complete  = 1'b0;
    holdStart = 1'b0;
    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (run_q && !empty) begin
            state_d = ISSUE;
            loadEn  = 1'b1;
          end
        end
        ISSUE: begin
          popEn = 1'b1;
          if (holdCnt_q != '0) begin
            state_d   = HOLD;
            holdStart = 1'b1;
          end else begin
            complete = 1'b1;
            if (run_q && (count_q > CW'(1))) begin
              state_d = ISSUE;
              loadEn  = 1'b1;
            end else begin
              state_d = IDLE;
            end
          end
        end
        HOLD: begin
          if (tick && (holdCnt_q == 13'd1)) begin
            complete = 1'b1;
            if (run_q && !empty) begin
              state_d = ISSUE;
              loadEn  = 1'b1;
            end else begin
              state_d = IDLE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    pw_we  = (state_q == ISSUE);
    busy   = (state_q != IDLE);
    intr   = drained_q & ie_q;
    pw_ch  = pwCh_q;
    pw_val = pwVal_q;
  end

  always_ff @(posedge clk) begin
    if (push) mem[wrPtr_q] <= wb.wb_dat_i;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rdPtr_q <= '0;
      wrPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (push)  wrPtr_q <= wrPtr_q + AW'(1);
      if (popEn) rdPtr_q <= rdPtr_q + AW'(1);
      count_q <= count_q + CW'(push) - CW'(popEn);
    end
  end

  always_comb begin
    readMux = '0;
    case (regSel)
      2'd1:    readMux = {7'd0, 9'(count_q), 11'd0, drained_q, ovf_q, empty, full,
                          (state_q != IDLE)};
      2'd2:    readMux = {29'd0, ie_q, 1'b0, run_q};
      2'd3:    readMux = {16'd0, done_q};
      default: readMux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ack_q     <= 1'b0;
      dat_q     <= '0;
      run_q     <= 1'b0;
      ie_q      <= 1'b0;
      ovf_q     <= 1'b0;
      drained_q <= 1'b0;
      done_q    <= '0;
      pwCh_q    <= '0;
      pwVal_q   <= '0;
      holdCnt_q <= '0;
      presc_q   <= '0;
    end else begin
      ack_q <= access;
      dat_q <= (access && !wb.wb_we_i) ? readMux : '0;
      if (ctrlWr) begin
        run_q <= wb.wb_dat_i[0];
        ie_q  <= wb.wb_dat_i[2];
      end
      if (statWr && wb.wb_dat_i[3]) ovf_q <= 1'b0;
      if (cmdWr && full)            ovf_q <= 1'b1;
      if (statWr && wb.wb_dat_i[4]) drained_q <= 1'b0;
      if (complete && drainNow)     drained_q <= 1'b1;
      if (doneWr)        done_q <= '0;
      else if (complete) done_q <= done_q + 16'd1;
      if (holdStart)             presc_q <= '0;
      else if (tick)             presc_q <= '0;
      else if (state_q == HOLD)  presc_q <= presc_q + 32'd1;
      if (loadEn) begin
        pwCh_q    <= headWord[31:29];
        pwVal_q   <= headWord[15:0];
        holdCnt_q <= headWord[28:16];
      end else if (tick) begin
        holdCnt_q <= holdCnt_q - 13'd1;
      end
    end
  end

  assign wb.wb_ack_o = ack_q;
  assign wb.wb_dat_o = dat_q;

endmodule

// File: doc/wb_move_seq.md
# wb_move_seq

Wishbone slave that queues servo move commands from the LM32 and replays them to the motor PWM block, one channel update at a time, holding each move for a programmed number of milliseconds. It sits on a free conbus slave port beside the PWM slave. It drives the PWM block's pulse-width load interface so that firmware can post a whole cube-turn sequence and take one interrupt when it finishes.

## Interface
- clk_freq, 100000000: clock frequency in Hz; one ms tick = clk_freq/1000 cycles.
- depth, 16: command FIFO entries; power of 2, 2..256.
- clk  in  1: system clock. One clock domain only.
- rst  in  1: synchronous, active-high reset.
- wb_adr_i  in  32: byte address; only [3:2] decoded.
- wb_dat_i  in  32: write data.
- wb_dat_o  out  32: read data; valid while wb_ack_o=1, 0 otherwise.
- wb_sel_i  in  4: ignored; all accesses are 32-bit.
- wb_stb_i, wb_cyc_i, wb_we_i  in  1 each: Wishbone classic strobe, cycle and write enable.
- wb_ack_o  out  1: single-cycle acknowledge.
- pw_we  out  1: one-cycle load strobe to the PWM block.
- pw_ch  out  3: target servo channel 0..7.
- pw_val  out  16: pulse width in µs.
- busy  out  1: 1 when the FSM is not in IDLE.
- intr  out  1: drained & ie, level.

## Operation
- Command word: [31:29] ch, [28:16] hold_ms (0..8191), [15:0] pulse width in µs.
- Register map:
  - 0x0 CMD. Write pushes one command. A write while the FIFO is full is dropped and sets ovf. This applies even if a pop happens in the same cycle. Reads return 0.
  - 0x4 STATUS. Read bits: [0] busy, [1] full, [2] empty, [3] ovf (sticky), [4] drained (sticky), [16+:9] count. Write: a 1 in bit 3 or bit 4 clears that flag.
  - 0x8 CTRL (read/write). Bit 0 run, bit 2 ie. Bit 1 is flush: it takes effect when written, does not store and reads 0.
  - 0xC DONE. 16-bit count of completed moves, wraps at 0xFFFF→0. Any write clears it.
- FSM states: IDLE, ISSUE, HOLD.
  - IDLE→ISSUE when run=1 and the FIFO is not empty. On that edge pw_ch/pw_val load from the FIFO head; the hold counter loads hold_ms.
  - ISSUE lasts exactly 1 cycle and pw_we=1 during it. The head is popped on the exit edge.
  - ISSUE exit with hold_ms≠0: go to HOLD and restart the ms prescaler.
  - ISSUE exit with hold_ms=0: the move completes immediately. Go to ISSUE again if run=1 and an entry remains (that entry is loaded on the same edge), otherwise go to IDLE.
  - HOLD decrements on each ms tick. At 0 the move completes: same next-state rule as hold_ms=0.
- Move completion: DONE+1. If the FIFO is empty after the pop, drained is set.
- Clearing run: the move in progress finishes. No further ISSUE.
- Flush: empties the FIFO and aborts HOLD→IDLE with no completion counted. pw_ch/pw_val keep their values. It does not set drained.
  - A flush in the same cycle as a CMD push: flush wins and the push is discarded.
- Simultaneous push and pop (FIFO not full): both occur and count is unchanged.
- FIFO pointers wrap modulo depth. count ranges 0..depth.

## Timing
- Reset values:
  - Outputs: wb_ack_o=0, wb_dat_o=0, pw_we=0, pw_ch=0, pw_val=0, busy=0, intr=0.
  - Internal: FIFO empty; run, ie, ovf and drained all 0; DONE=0; state IDLE.
- Bus handshake:
  - wb_ack_o rises the cycle after stb&cyc is sampled while ack=0, and drops the next cycle. A held strobe therefore gets an ack every 2nd cycle.
  - A write commits on the edge that raises ack.
- Latency: with run=1 and the FSM in IDLE, a CMD write's ack cycle is followed immediately by the pw_we cycle.
- Hold time: HOLD lasts exactly hold_ms*(clk_freq/1000) cycles. Each move occupies 1 + that many cycles.
- Back-to-back hold_ms=0 moves give pw_we on consecutive cycles.
- Reset asserted mid-move: immediate return to reset state, with no pw_we or completion.

## Test plan
All scenarios use clk_freq=8000, i.e. 8 cycles/ms.
- Single move: reset, CTRL=1, CMD={ch=2, hold=3, pw=1500} → pw_we in the cycle after ack with pw_ch=2 and pw_val=1500. busy stays high for 1+24 cycles. DONE=1, drained=1, intr=0.
- Queue and interrupt: CTRL=0b101, queue 4 moves of hold 1 ms → 4 pw_we pulses 9 cycles apart, DONE=4, intr=1. Writing STATUS bit4=1 → intr=0.
- Overflow: run=0, write 17 CMDs → count=16, full=1, ovf=1. The 17th is absent: draining with run=1 gives exactly 16 pw_we.
- Zero hold: queue 3 moves with hold=0 → pw_we on 3 consecutive cycles with the correct ch/val each, DONE=3.
- Run stop / flush: a 4-move queue; clear run during move 1's HOLD → move 1 completes, then IDLE with count=3. Flush → count=0, DONE unchanged, pw_val still move 1's.
- Reset mid-HOLD: assert rst → all outputs at reset values next cycle, FIFO empty, no further pw_we.
